// File: rtl/hub75_scanout.sv
// HUB75 scan-out engine: reads RGB565 pixels from the line framebuffer and drives a
// 64x32, 1/16-scan panel with 6-plane binary-coded modulation.
module hub75_scanout #(
    parameter int PIXELS_PER_ROW  = 64,
    parameter int BRIGHTNESS_BASE = 8
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [7:0]  ram_data_in,
    input  logic [2:0]  rgb_enable,
    input  logic [5:0]  brightness_enable,
    output logic [11:0] ram_address,
    output logic        ram_clk_enable,
    output logic [2:0]  rgb1,
    output logic [2:0]  rgb2,
    output logic [3:0]  row_address,
    output logic        pixel_clock,
    output logic        latch,
    output logic        output_enable
);

    typedef enum logic [1:0] {SHIFT, BLANK, LATCH, DISPLAY} state_t;

    localparam logic [5:0]  LastCol  = 6'(PIXELS_PER_ROW - 1);
    localparam logic [15:0] DispBase = 16'(BRIGHTNESS_BASE);

    // The state registers name the cycle that the next clock edge will put on the pins.
    state_t      state_q;
    logic [5:0]  col_q;
    logic [2:0]  phase_q;
    logic [2:0]  plane_q;
    logic [3:0]  row_q;
    logic [15:0] disp_cnt_q;
    logic        disp_first_q;
    logic [7:0]  up_lo_q;
    logic [7:0]  up_hi_q;
    logic [7:0]  lo_lo_q;
    logic        live_q;
    logic [2:0]  rgb1_q;
    logic [2:0]  rgb2_q;
    logic [2:0]  rgb1_d;
    logic [2:0]  rgb2_d;
    logic [11:0] ram_address_q;
    logic        ram_clk_enable_q;
    logic [3:0]  row_address_q;
    logic        pixel_clock_q;
    logic        latch_q;
    logic        output_enable_q;

    function automatic logic [2:0] plane_bits(input logic [15:0] word, input logic [2:0] plane);
        logic [5:0] r6;
        logic [5:0] g6;
        logic [5:0] b6;
        r6 = {word[15:11], word[15]};
        g6 = word[10:5];
        b6 = {word[4:0], word[4]};
        return {b6[plane], g6[plane], r6[plane]};
    endfunction

    // The last byte is taken straight from the RAM port so colour is valid during P4.
    always_comb begin
        rgb1_d = plane_bits({up_hi_q, up_lo_q}, plane_q) & rgb_enable;
        rgb2_d = plane_bits({ram_data_in, lo_lo_q}, plane_q) & rgb_enable;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q          <= SHIFT;
            col_q            <= '0;
            phase_q          <= '0;
            plane_q          <= '0;
            row_q            <= '0;
            disp_cnt_q       <= '0;
            disp_first_q     <= 1'b0;
            up_lo_q          <= '0;
            up_hi_q          <= '0;
            lo_lo_q          <= '0;
            live_q           <= 1'b0;
            rgb1_q           <= '0;
            rgb2_q           <= '0;
            ram_address_q    <= '0;
            ram_clk_enable_q <= 1'b0;
            row_address_q    <= '0;
            pixel_clock_q    <= 1'b0;
            latch_q          <= 1'b0;
            output_enable_q  <= 1'b1;
        end else begin
            ram_clk_enable_q <= 1'b0;
            pixel_clock_q    <= 1'b0;
            latch_q          <= 1'b0;
            live_q           <= 1'b0;
            case (state_q)
                SHIFT: begin
                    output_enable_q <= 1'b1;
                    if (phase_q < 3'd4) begin
                        ram_clk_enable_q <= 1'b1;
                        ram_address_q    <= {phase_q[1], row_q, col_q, phase_q[0]};
                    end
                    case (phase_q)
                        3'd2: up_lo_q <= ram_data_in;
                        3'd3: up_hi_q <= ram_data_in;
                        3'd4: begin
                            lo_lo_q <= ram_data_in;
                            live_q  <= 1'b1;
                        end
                        3'd5: begin
                            rgb1_q        <= rgb1_d;
                            rgb2_q        <= rgb2_d;
                            pixel_clock_q <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (phase_q == 3'd5) begin
                        phase_q <= '0;
                        if (col_q == LastCol) begin
                            col_q   <= '0;
                            state_q <= BLANK;
                        end else begin
                            col_q <= col_q + 6'd1;
                        end
                    end else begin
                        phase_q <= phase_q + 3'd1;
                    end
                end
                BLANK: begin
                    output_enable_q <= 1'b1;
                    row_address_q   <= row_q;
                    state_q         <= LATCH;
                end
                LATCH: begin
                    output_enable_q <= 1'b1;
                    latch_q         <= 1'b1;
                    disp_cnt_q      <= (DispBase << plane_q) - 16'd1;
                    disp_first_q    <= 1'b1;
                    state_q         <= DISPLAY;
                end
                DISPLAY: begin
                    // Plane gate is sampled once on entry and held for the whole period.
                    if (disp_first_q) begin
                        output_enable_q <= ~brightness_enable[plane_q];
                        disp_first_q    <= 1'b0;
                    end
                    if (disp_cnt_q == 16'd0) begin
                        state_q <= SHIFT;
                        if (plane_q == 3'd5) begin
                            plane_q <= '0;
                            row_q   <= row_q + 4'd1;
                        end else begin
                            plane_q <= plane_q + 3'd1;
                        end
                    end else begin
                        disp_cnt_q <= disp_cnt_q - 16'd1;
                    end
                end
                default: state_q <= SHIFT;
            endcase
        end
    end

    assign ram_address    = ram_address_q;
    assign ram_clk_enable = ram_clk_enable_q;
    assign rgb1           = live_q ? rgb1_d : rgb1_q;
    assign rgb2           = live_q ? rgb2_d : rgb2_q;
    assign row_address    = row_address_q;
    assign pixel_clock    = pixel_clock_q;
    assign latch          = latch_q;
    assign output_enable  = output_enable_q;

endmodule

// File: tb/tb_hub75_scanout.sv
// Bench for hub75_scanout: RAM model plus a cycle-position reference model derived
// from the scan timing rules (plane lengths, slot phases, memory map).
module tb_hub75_scanout;

    localparam int PixelsPerRow   = 64;
    localparam int BrightnessBase = 8;
    localparam int ShiftCycles    = PixelsPerRow * 6;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ram_data_in = '0;
    logic [2:0]  rgb_enable = 3'b111;
    logic [5:0]  brightness_enable = 6'h3F;
    logic [11:0] ram_address;
    logic        ram_clk_enable;
    logic [2:0]  rgb1;
    logic [2:0]  rgb2;
    logic [3:0]  row_address;
    logic        pixel_clock;
    logic        latch;
    logic        output_enable;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] mem [4096];

    hub75_scanout #(
        .PIXELS_PER_ROW(PixelsPerRow),
        .BRIGHTNESS_BASE(BrightnessBase)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .ram_data_in(ram_data_in),
        .rgb_enable(rgb_enable),
        .brightness_enable(brightness_enable),
        .ram_address(ram_address),
        .ram_clk_enable(ram_clk_enable),
        .rgb1(rgb1),
        .rgb2(rgb2),
        .row_address(row_address),
        .pixel_clock(pixel_clock),
        .latch(latch),
        .output_enable(output_enable)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_clk_enable) ram_data_in <= mem[ram_address];
    end

    function automatic int planeLen(int b);
        return ShiftCycles + 2 + (BrightnessBase << b);
    endfunction

    function automatic int rowPeriod();
        int sum;
        sum = 0;
        for (int b = 0; b < 6; b++) sum += planeLen(b);
        return sum;
    endfunction

    // Cycle n (n-th edge after reset release) -> panel row, plane and offset inside the plane.
    task automatic locate(input int n, output int row, output int plane, output int q);
        int o;
        o = (n - 1) % rowPeriod();
        row = ((n - 1) / rowPeriod()) % 16;
        plane = 0;
        while (o >= planeLen(plane)) begin
            o -= planeLen(plane);
            plane++;
        end
        q = o;
    endtask

    function automatic logic [2:0] pixelBits(int half, int row, int col, int plane, logic [2:0] en);
        int a, r, g, bl, r6, b6;
        logic [15:0] w;
        logic [2:0] bits;
        a = half * 2048 + row * 128 + col * 2;
        w = {mem[a + 1], mem[a]};
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        bl = int'(w[4:0]);
        r6 = (r << 1) | (r >> 4);
        b6 = (bl << 1) | (bl >> 4);
        bits[0] = ((r6 >> plane) & 1) != 0;
        bits[1] = ((g >> plane) & 1) != 0;
        bits[2] = ((b6 >> plane) & 1) != 0;
        return bits & en;
    endfunction

    task automatic fillMem(input bit randomData);
        for (int i = 0; i < 4096; i++) mem[i] = randomData ? 8'($urandom) : 8'h00;
    endtask

    task automatic applyReset();
        @(negedge clk_in);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors += 7;
        if (ram_address !== 12'h000) begin miscompares++; $display("[TB] FAIL reset_addr got %h want 000", ram_address); end
        if (ram_clk_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ce got %b want 0", ram_clk_enable); end
        if (rgb1 !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_rgb1 got %b want 000", rgb1); end
        if (rgb2 !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_rgb2 got %b want 000", rgb2); end
        if (row_address !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_row got %h want 0", row_address); end
        if (pixel_clock !== 1'b0 || latch !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pclk_latch got %b%b want 00", pixel_clock, latch); end
        if (output_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_oe got %b want 1", output_enable); end
    endtask

    task automatic test_first_addresses();
        logic [11:0] firstAddr [4];
        firstAddr[0] = 12'h000;
        firstAddr[1] = 12'h001;
        firstAddr[2] = 12'h800;
        firstAddr[3] = 12'h801;
        fillMem(1'b0);
        rgb_enable = 3'b111;
        brightness_enable = 6'h00;
        applyReset();
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk_in);
            vectors++;
            if (output_enable !== 1'b1 || rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL zero_ram cycle %0d got oe=%b rgb1=%b rgb2=%b want 1/000/000", n, output_enable, rgb1, rgb2);
            end
            if (n <= 4) begin
                vectors++;
                if (ram_clk_enable !== 1'b1 || ram_address !== firstAddr[n - 1]) begin
                    miscompares++;
                    $display("[TB] FAIL first_addr cycle %0d got ce=%b addr=%h want 1/%h", n, ram_clk_enable, ram_address, firstAddr[n - 1]);
                end
            end
            if (n <= 6) begin
                vectors++;
                if (pixel_clock !== (n == 6)) begin
                    miscompares++;
                    $display("[TB] FAIL first_pclk cycle %0d got %b want %b", n, pixel_clock, n == 6);
                end
            end
        end
    endtask

    task automatic test_color_gates();
        int row, plane, q;
        logic [2:0] exp1;
        for (int pass = 0; pass < 2; pass++) begin
            fillMem(1'b0);
            mem[12'h001] = 8'hF8;
            mem[12'h800] = 8'h1F;
            rgb_enable = (pass == 0) ? 3'b111 : 3'b110;
            exp1 = (pass == 0) ? 3'b001 : 3'b000;
            brightness_enable = 6'h3F;
            applyReset();
            for (int n = 1; n <= rowPeriod(); n++) begin
                @(negedge clk_in);
                locate(n, row, plane, q);
                if (q == 5) begin
                    vectors += 2;
                    if (rgb1 !== exp1) begin
                        miscompares++;
                        $display("[TB] FAIL gate_rgb1 en=%b plane %0d got %b want %b", rgb_enable, plane, rgb1, exp1);
                    end
                    if (rgb2 !== 3'b100) begin
                        miscompares++;
                        $display("[TB] FAIL gate_rgb2 en=%b plane %0d got %b want 100", rgb_enable, plane, rgb2);
                    end
                end
            end
        end
    endtask

    task automatic test_brightness();
        int row, plane, q;
        int darkCnt [6];
        int idle5;
        fillMem(1'b1);
        rgb_enable = 3'b111;
        brightness_enable = 6'b000001;
        for (int b = 0; b < 6; b++) darkCnt[b] = 0;
        idle5 = 0;
        applyReset();
        for (int n = 1; n <= rowPeriod(); n++) begin
            @(negedge clk_in);
            locate(n, row, plane, q);
            if (output_enable === 1'b0) darkCnt[plane]++;
            if (plane == 5 && q >= ShiftCycles + 2 && output_enable === 1'b1) idle5++;
        end
        for (int b = 0; b < 6; b++) begin
            vectors++;
            if (darkCnt[b] !== ((b == 0) ? BrightnessBase : 0)) begin
                miscompares++;
                $display("[TB] FAIL plane_lit plane %0d got %0d want %0d", b, darkCnt[b], (b == 0) ? BrightnessBase : 0);
            end
        end
        vectors++;
        if (idle5 !== (BrightnessBase << 5)) begin
            miscompares++;
            $display("[TB] FAIL plane5_dark got %0d want %0d", idle5, BrightnessBase << 5);
        end
    endtask

    task automatic test_free_run();
        int row, plane, q, col, ph, rgbCol, pclkCount, lastRowChange, rowChanges, total;
        bit shift, haveRgb;
        logic expCe, expPclk, expLatch, expOe;
        logic [11:0] expAddr;
        logic [3:0] expRowAddr, prevRowAddr;
        logic [2:0] enUsed, exp1, exp2;
        logic [5:0] beSampled;
        fillMem(1'b1);
        rgb_enable = 3'($urandom_range(0, 7));
        brightness_enable = 6'($urandom);
        applyReset();
        total = 16 * rowPeriod() + 400;
        expRowAddr = 4'h0;
        prevRowAddr = 4'h0;
        enUsed = rgb_enable;
        beSampled = brightness_enable;
        pclkCount = 0;
        lastRowChange = -1;
        rowChanges = 0;
        for (int n = 1; n <= total; n++) begin
            @(negedge clk_in);
            locate(n, row, plane, q);
            shift = q < ShiftCycles;
            col = q / 6;
            ph = q % 6;
            if (shift) enUsed = rgb_enable;
            if (q == ShiftCycles) expRowAddr = 4'(row);
            if (q == ShiftCycles + 1) beSampled = brightness_enable;
            expCe = shift && ph < 4;
            expAddr = 12'(((ph >= 2) ? 2048 : 0) + row * 128 + col * 2 + ph % 2);
            expPclk = shift && ph == 5;
            expLatch = (q == ShiftCycles + 1);
            expOe = (q >= ShiftCycles + 2) ? ~beSampled[plane] : 1'b1;
            vectors += 5;
            if (ram_clk_enable !== expCe) begin miscompares++; $display("[TB] FAIL run_ce cycle %0d got %b want %b", n, ram_clk_enable, expCe); end
            if (pixel_clock !== expPclk) begin miscompares++; $display("[TB] FAIL run_pclk cycle %0d got %b want %b", n, pixel_clock, expPclk); end
            if (latch !== expLatch) begin miscompares++; $display("[TB] FAIL run_latch cycle %0d got %b want %b", n, latch, expLatch); end
            if (output_enable !== expOe) begin miscompares++; $display("[TB] FAIL run_oe cycle %0d got %b want %b", n, output_enable, expOe); end
            if (row_address !== expRowAddr) begin miscompares++; $display("[TB] FAIL run_row cycle %0d got %h want %h", n, row_address, expRowAddr); end
            if (expCe) begin
                vectors++;
                if (ram_address !== expAddr) begin miscompares++; $display("[TB] FAIL run_addr cycle %0d got %h want %h", n, ram_address, expAddr); end
            end
            haveRgb = 1'b1;
            rgbCol = PixelsPerRow - 1;
            if (shift && ph >= 4) rgbCol = col;
            else if (shift && col > 0) rgbCol = col - 1;
            else if (shift) haveRgb = 1'b0;
            if (haveRgb) begin
                exp1 = pixelBits(0, row, rgbCol, plane, enUsed);
                exp2 = pixelBits(1, row, rgbCol, plane, enUsed);
                vectors += 2;
                if (rgb1 !== exp1) begin miscompares++; $display("[TB] FAIL run_rgb1 cycle %0d got %b want %b", n, rgb1, exp1); end
                if (rgb2 !== exp2) begin miscompares++; $display("[TB] FAIL run_rgb2 cycle %0d got %b want %b", n, rgb2, exp2); end
            end
            if (pixel_clock === 1'b1) pclkCount++;
            if (latch === 1'b1) begin
                vectors++;
                if (pclkCount !== PixelsPerRow) begin miscompares++; $display("[TB] FAIL latch_pclks cycle %0d got %0d want %0d", n, pclkCount, PixelsPerRow); end
                pclkCount = 0;
            end
            if (row_address !== prevRowAddr) begin
                vectors++;
                if (row_address !== 4'(prevRowAddr + 4'd1)) begin miscompares++; $display("[TB] FAIL row_step got %h want %h", row_address, 4'(prevRowAddr + 4'd1)); end
                if (lastRowChange >= 0) begin
                    vectors++;
                    if (n - lastRowChange !== rowPeriod()) begin miscompares++; $display("[TB] FAIL row_period got %0d want %0d", n - lastRowChange, rowPeriod()); end
                end
                lastRowChange = n;
                prevRowAddr = row_address;
                rowChanges++;
            end
            if (q == ShiftCycles + 2) begin
                rgb_enable = 3'($urandom_range(0, 7));
                brightness_enable = 6'($urandom);
            end
        end
        vectors++;
        if (rowChanges !== 16) begin miscompares++; $display("[TB] FAIL row_wrap got %0d changes want 16", rowChanges); end
    endtask

    task automatic test_reset_mid_display();
        fillMem(1'b1);
        rgb_enable = 3'b111;
        brightness_enable = 6'h3F;
        applyReset();
        repeat (ShiftCycles + 6) @(negedge clk_in);
        vectors++;
        if (output_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_lit got %b want 0", output_enable); end
        #1 reset = 1'b0;
        #1;
        vectors += 2;
        if (output_enable !== 1'b1) begin miscompares++; $display("[TB] FAIL async_oe got %b want 1", output_enable); end
        if (latch !== 1'b0 || ram_clk_enable !== 1'b0 || ram_address !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL async_outs got latch=%b ce=%b addr=%h want 0/0/000", latch, ram_clk_enable, ram_address);
        end
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        vectors++;
        if (ram_clk_enable !== 1'b1 || ram_address !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL restart_addr got ce=%b addr=%h want 1/000", ram_clk_enable, ram_address);
        end
    endtask

    initial begin
        test_reset();
        test_first_addresses();
        test_color_gates();
        test_brightness();
        test_free_run();
        test_reset_mid_display();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
